// File: rtl/execute_stage_if.sv
// Bundle of the decode-side, hazard-unit and EX-side signals around the EX stage.
interface execute_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) ();
  // Hazard-unit controls
  logic            StallE;
  logic            FlushE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  // Decode-side payload
  logic [2:0]      ALUControlD;
  logic            ShiftArithD;
  logic            ALUSrcD;
  logic            RegWriteD;
  logic            MemWriteD;
  logic            BranchD;
  logic            JumpD;
  logic [1:0]      ResultSrcD;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ImmExtD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [RW-1:0]   Rs1D;
  logic [RW-1:0]   Rs2D;
  logic [RW-1:0]   RdD;
  // Forwarded values from later stages
  logic [XLEN-1:0] ResultW;
  logic [XLEN-1:0] ALUResultM;
  // EX-side results
  logic [XLEN-1:0] ALUResultE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] PCTargetE;
  logic            PCSrcE;
  logic            ZeroE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [RW-1:0]   RdE;
  logic [RW-1:0]   Rs1E;
  logic [RW-1:0]   Rs2E;
  logic [XLEN-1:0] PCPlus4E;

  modport master (
    output StallE, FlushE, ForwardAE, ForwardBE,
    output ALUControlD, ShiftArithD, ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD,
    output ResultSrcD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    output ResultW, ALUResultM,
    input  ALUResultE, WriteDataE, PCTargetE, PCSrcE, ZeroE, RegWriteE, MemWriteE,
    input  ResultSrcE, RdE, Rs1E, Rs2E, PCPlus4E
  );

  modport slave (
    input  StallE, FlushE, ForwardAE, ForwardBE,
    input  ALUControlD, ShiftArithD, ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD,
    input  ResultSrcD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    input  ResultW, ALUResultM,
    output ALUResultE, WriteDataE, PCTargetE, PCSrcE, ZeroE, RegWriteE, MemWriteE,
    output ResultSrcE, RdE, Rs1E, Rs2E, PCPlus4E
  );
endinterface

// File: rtl/execute_stage.sv
// EX pipeline stage: ID/EX register with stall/flush, forwarding muxes, ALU and branch resolution.
module execute_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);

  localparam int unsigned SHW = 5;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic            shift_arith;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
  } idex_t;

  idex_t idex_q, idex_d;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_result;
  logic [SHW-1:0]  shamt;
  logic            zero;

  // ID/EX next state: flush beats stall, stall holds, otherwise capture decode fields
  always_comb begin
    idex_d = idex_q;
    if (ex.FlushE) begin
      idex_d = '0;
    end else if (!ex.StallE) begin
      idex_d.reg_write   = ex.RegWriteD;
      idex_d.mem_write   = ex.MemWriteD;
      idex_d.branch      = ex.BranchD;
      idex_d.jump        = ex.JumpD;
      idex_d.result_src  = ex.ResultSrcD;
      idex_d.alu_control = ex.ALUControlD;
      idex_d.shift_arith = ex.ShiftArithD;
      idex_d.alu_src     = ex.ALUSrcD;
      idex_d.rd1         = ex.RD1D;
      idex_d.rd2         = ex.RD2D;
      idex_d.imm         = ex.ImmExtD;
      idex_d.pc          = ex.PCD;
      idex_d.pc_plus4    = ex.PCPlus4D;
      idex_d.rs1         = ex.Rs1D;
      idex_d.rs2         = ex.Rs2D;
      idex_d.rd          = ex.RdD;
    end
  end

  // ID/EX register; reset inserts a bubble
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  // Forwarding muxes; select 11 falls back to the register-file value
  always_comb begin
    src_a = idex_q.rd1;
    unique case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALUResultM;
      default: src_a = idex_q.rd1;
    endcase
    write_data = idex_q.rd2;
    unique case (ex.ForwardBE)
      2'b01:   write_data = ex.ResultW;
      2'b10:   write_data = ex.ALUResultM;
      default: write_data = idex_q.rd2;
    endcase
    src_b = idex_q.alu_src ? idex_q.imm : write_data;
  end

  // ALU
  always_comb begin
    shamt      = src_b[SHW-1:0];
    alu_result = '0;
    unique case (idex_q.alu_control)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = XLEN'($signed(src_a) < $signed(src_b));
      3'b110: alu_result = src_a << shamt;
      3'b111: alu_result = idex_q.shift_arith ? XLEN'($signed(src_a) >>> shamt)
                                              : (src_a >> shamt);
      default: alu_result = '0;
    endcase
    zero = (alu_result == '0);
  end

  assign ex.ALUResultE = alu_result;
  assign ex.ZeroE      = zero;
  assign ex.WriteDataE = write_data;
  assign ex.PCTargetE  = idex_q.pc + idex_q.imm;
  assign ex.PCSrcE     = (idex_q.branch & zero) | idex_q.jump;
  assign ex.RegWriteE  = idex_q.reg_write;
  assign ex.MemWriteE  = idex_q.mem_write;
  assign ex.ResultSrcE = idex_q.result_src;
  assign ex.RdE        = idex_q.rd;
  assign ex.Rs1E       = idex_q.rs1;
  assign ex.Rs2E       = idex_q.rs2;
  assign ex.PCPlus4E   = idex_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand sequences, random vs model.
module tb_execute_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .rst(rst), .ex(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot of what the EX stage should currently hold
  typedef struct packed {
    logic        rw, mw, br, jp;
    logic [1:0]  rsrc;
    logic [2:0]  ctl;
    logic        sa, as;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  r1, r2, rd;
  } snap_t;

  typedef struct {
    logic [2:0]  ctl;
    logic        sa, as, br, jp;
    logic [31:0] rd1, rd2, imm, pc;
    logic [1:0]  fa, fb;
    logic [31:0] resw, alum, e_alu;
    logic        e_zero, e_pcsrc;
    logic [31:0] e_tgt, e_wd;
  } vec_t;

  snap_t m;
  vec_t  vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic snap_t capture();
    snap_t s;
    s.rw = bus.RegWriteD;  s.mw = bus.MemWriteD; s.br = bus.BranchD; s.jp = bus.JumpD;
    s.rsrc = bus.ResultSrcD; s.ctl = bus.ALUControlD; s.sa = bus.ShiftArithD;
    s.as = bus.ALUSrcD; s.rd1 = bus.RD1D; s.rd2 = bus.RD2D; s.imm = bus.ImmExtD;
    s.pc = bus.PCD; s.pc4 = bus.PCPlus4D; s.r1 = bus.Rs1D; s.r2 = bus.Rs2D; s.rd = bus.RdD;
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b01) return bus.ResultW;
    if (sel == 2'b10) return bus.ALUResultM;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input snap_t s, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    int          ia, ib;
    sh = int'(b % 32);
    ia = a;
    ib = b;
    case (s.ctl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (ia < ib) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return (s.sa && a[31]) ? ~((~a) >> sh) : (a >> sh);
    endcase
  endfunction

  // Compare every EX output against the model snapshot and current forwarding inputs
  task automatic check_model(input string tag);
    logic [31:0] a, wd, b, r;
    a  = pick(bus.ForwardAE, m.rd1);
    wd = pick(bus.ForwardBE, m.rd2);
    b  = m.as ? m.imm : wd;
    r  = ref_alu(m, a, b);
    chk({tag, ".alu"},    bus.ALUResultE, r);
    chk({tag, ".zero"},   32'(bus.ZeroE), 32'(r == 32'd0));
    chk({tag, ".wd"},     bus.WriteDataE, wd);
    chk({tag, ".tgt"},    bus.PCTargetE, m.pc + m.imm);
    chk({tag, ".pcsrc"},  32'(bus.PCSrcE), 32'(m.jp || (m.br && r == 32'd0)));
    chk({tag, ".ctl"},    {24'd0, bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, 4'd0},
                          {24'd0, m.rw, m.mw, m.rsrc, 4'd0});
    chk({tag, ".regs"},   {17'd0, bus.RdE, bus.Rs1E, bus.Rs2E}, {17'd0, m.rd, m.r1, m.r2});
    chk({tag, ".pc4"},    bus.PCPlus4E, m.pc4);
  endtask

  // One clock: update the model with the priority rst > flush > stall > capture
  task automatic step();
    @(posedge clk);
    if (rst)              m = '0;
    else if (bus.FlushE)  m = '0;
    else if (!bus.StallE) m = capture();
    #1;
  endtask

  task automatic drive_instr(input logic [2:0] ctl, input logic sa, input logic as,
                             input logic br, input logic jp, input logic [31:0] rd1,
                             input logic [31:0] rd2, input logic [31:0] imm,
                             input logic [31:0] pc, input int idx);
    bus.ALUControlD = ctl; bus.ShiftArithD = sa; bus.ALUSrcD = as;
    bus.BranchD = br; bus.JumpD = jp; bus.RegWriteD = 1'b1; bus.MemWriteD = 1'b0;
    bus.ResultSrcD = 2'b01; bus.RD1D = rd1; bus.RD2D = rd2; bus.ImmExtD = imm;
    bus.PCD = pc; bus.PCPlus4D = pc + 32'd4;
    bus.Rs1D = 5'(idx); bus.Rs2D = 5'(idx + 1); bus.RdD = 5'(idx + 2);
  endtask

  task automatic randomize_d();
    bus.ALUControlD = 3'($urandom); bus.ShiftArithD = 1'($urandom); bus.ALUSrcD = 1'($urandom);
    bus.BranchD = 1'($urandom); bus.JumpD = ($urandom_range(0, 5) == 0);
    bus.RegWriteD = 1'($urandom); bus.MemWriteD = 1'($urandom); bus.ResultSrcD = 2'($urandom);
    bus.RD1D = $urandom;
    bus.RD2D = ($urandom_range(0, 3) == 0) ? bus.RD1D : $urandom;
    bus.ImmExtD = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
    bus.PCD = $urandom; bus.PCPlus4D = $urandom;
    bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom); bus.RdD = 5'($urandom);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m      = '0;

    // Directed vectors
    //          ctl     sa  as  br  jp  rd1           rd2           imm         pc          fa     fb     resw    alum    e_alu         zero pcsrc e_tgt      e_wd
    vt[0]  = '{3'b000, 0, 0, 0, 0, 32'd5,        32'd7,        32'd0,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'd12,       0,   0,    32'd0,     32'd7};
    vt[1]  = '{3'b001, 0, 0, 0, 0, 32'd5,        32'd7,        32'd0,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'hFFFFFFFE, 0,   0,    32'd0,     32'd7};
    vt[2]  = '{3'b111, 1, 1, 0, 0, 32'h80000000, 32'd0,        32'd4,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'hF8000000, 0,   0,    32'd4,     32'd0};
    vt[3]  = '{3'b111, 0, 1, 0, 0, 32'h80000000, 32'd0,        32'd4,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'h08000000, 0,   0,    32'd4,     32'd0};
    vt[4]  = '{3'b101, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd0,        32'd1,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'd1,        0,   0,    32'd1,     32'd0};
    vt[5]  = '{3'b000, 0, 0, 0, 0, 32'd100,      32'd200,      32'd0,      32'd0,      2'b10, 2'b01, 32'd3,  32'd9,  32'd12,       0,   0,    32'd0,     32'd3};
    vt[6]  = '{3'b001, 0, 0, 1, 0, 32'd4,        32'd4,        32'h20,     32'h100,    2'b00, 2'b00, 32'd0,  32'd0,  32'd0,        1,   1,    32'h120,   32'd4};
    vt[7]  = '{3'b000, 0, 0, 0, 1, 32'd1,        32'd2,        32'h10,     32'h200,    2'b00, 2'b00, 32'd0,  32'd0,  32'd3,        0,   1,    32'h210,   32'd2};
    vt[8]  = '{3'b001, 0, 0, 1, 0, 32'd4,        32'd5,        32'd0,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'hFFFFFFFF, 0,   0,    32'd0,     32'd5};
    vt[9]  = '{3'b100, 0, 0, 0, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,      32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'hFF000FF0, 0,   0,    32'd0,     32'h0FF00F0F};
    vt[10] = '{3'b110, 0, 1, 0, 0, 32'd1,        32'd0,        32'h23,     32'd0,      2'b00, 2'b00, 32'd0,  32'd0,  32'd8,        0,   0,    32'h23,    32'd0};
    vt[11] = '{3'b000, 0, 0, 0, 0, 32'd10,       32'd5,        32'd0,      32'd0,      2'b11, 2'b11, 32'd77, 32'd99, 32'd15,       0,   0,    32'd0,     32'd5};

    // Reset for two cycles with all inputs idle
    rst = 1'b1;
    bus.StallE = 1'b0; bus.FlushE = 1'b0; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
    bus.ResultW = '0; bus.ALUResultM = '0;
    drive_instr(3'b000, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    bus.RegWriteD = 1'b0;
    step();
    step();
    chk("rst.alu",   bus.ALUResultE, 32'd0);
    chk("rst.zero",  32'(bus.ZeroE), 32'd1);
    chk("rst.pcsrc", 32'(bus.PCSrcE), 32'd0);
    chk("rst.rw",    32'(bus.RegWriteE), 32'd0);
    check_model("rst");
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive_instr(vt[i].ctl, vt[i].sa, vt[i].as, vt[i].br, vt[i].jp,
                  vt[i].rd1, vt[i].rd2, vt[i].imm, vt[i].pc, i);
      bus.ForwardAE = vt[i].fa; bus.ForwardBE = vt[i].fb;
      bus.ResultW = vt[i].resw; bus.ALUResultM = vt[i].alum;
      step();
      chk($sformatf("vec%0d.alu", i),   bus.ALUResultE, vt[i].e_alu);
      chk($sformatf("vec%0d.zero", i),  32'(bus.ZeroE), 32'(vt[i].e_zero));
      chk($sformatf("vec%0d.pcsrc", i), 32'(bus.PCSrcE), 32'(vt[i].e_pcsrc));
      chk($sformatf("vec%0d.tgt", i),   bus.PCTargetE, vt[i].e_tgt);
      chk($sformatf("vec%0d.wd", i),    bus.WriteDataE, vt[i].e_wd);
      check_model($sformatf("vec%0d", i));
    end
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;

    // Stall holds for three cycles while decode inputs change, then flush beats stall
    drive_instr(3'b000, 0, 0, 0, 1, 32'h11, 32'h22, 32'h8, 32'h40, 3);
    step();
    bus.StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      randomize_d();
      step();
      chk($sformatf("stall%0d.alu", k),   bus.ALUResultE, 32'h33);
      chk($sformatf("stall%0d.rw", k),    32'(bus.RegWriteE), 32'd1);
      chk($sformatf("stall%0d.pcsrc", k), 32'(bus.PCSrcE), 32'd1);
      chk($sformatf("stall%0d.tgt", k),   bus.PCTargetE, 32'h48);
    end
    bus.FlushE = 1'b1;
    step();
    chk("flush.rw",    32'(bus.RegWriteE), 32'd0);
    chk("flush.mw",    32'(bus.MemWriteE), 32'd0);
    chk("flush.pcsrc", 32'(bus.PCSrcE), 32'd0);
    chk("flush.zero",  32'(bus.ZeroE), 32'd1);
    bus.FlushE = 1'b0; bus.StallE = 1'b0;

    // Reset in the middle of an in-flight jump discards it
    drive_instr(3'b011, 0, 0, 0, 1, 32'h5, 32'hA, 32'h4, 32'h80, 7);
    step();
    chk("inflight.alu", bus.ALUResultE, 32'hF);
    rst = 1'b1;
    step();
    chk("midrst.alu",   bus.ALUResultE, 32'd0);
    chk("midrst.zero",  32'(bus.ZeroE), 32'd1);
    chk("midrst.pcsrc", 32'(bus.PCSrcE), 32'd0);
    chk("midrst.tgt",   bus.PCTargetE, 32'd0);
    chk("midrst.rw",    32'(bus.RegWriteE), 32'd0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      randomize_d();
      rst        = ($urandom_range(0, 49) == 0);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      bus.StallE = ($urandom_range(0, 5) == 0);
      step();
      bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      bus.ResultW = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.ALUResultM = $urandom;
      #1;
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
